// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: FSM encoding,
// 8x16 register-file geometry and the default lock budget.
package regfile_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int RF_AW        = 3;
  localparam int RF_DW        = 16;
  localparam int RF_NREGS     = 8;
  localparam int LOCK_MAX_DEF = 16;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester handshake bundle plus the register-file write port.
// master = requester/register-file side, slave = arbiter.
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [AW*NREQ-1:0] req_dr;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               regWE;
  logic [AW-1:0]      DR;
  logic [DW-1:0]      Buss;

  modport master (
    output req_valid, req_lock, req_dr, req_data,
    input  req_ready, regWE, DR, Buss
  );

  modport slave (
    input  req_valid, req_lock, req_dr, req_data,
    output req_ready, regWE, DR, Buss
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational masked priority picker: first set request after ptr (wrapping)
// wins; returns one-hot grant, its index and an any-request flag.
module regfile_wr_arbiter_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates NREQ requesters onto the register-file write port: 1-cycle registered
// write, no back-pressure; lock with timeout. REGWR_ARB_RR_EN selects round-robin.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_wr_arbiter_if.slave     bus,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    locked,
  output logic                    lock_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           regwe_q, regwe_d;
  logic [AW-1:0]  dr_q, dr_d;
  logic [DW-1:0]  buss_q, buss_d;
  logic           lock_timeout_q, lock_timeout_d;

  logic [NREQ-1:0] pick_gnt, gnt;
  logic [IW-1:0]   pick_idx, pick_ptr, sel_idx;
  logic            pick_any, xfer;

`ifdef REGWR_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = IW'(NREQ - 1);
`endif

  regfile_wr_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    lock_timeout_d = 1'b0;
    gnt            = '0;
    sel_idx        = pick_idx;
`ifdef REGWR_ARB_RR_EN
    ptr_d          = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt = pick_gnt;
        if (pick_any) begin
`ifdef REGWR_ARB_RR_EN
          ptr_d = pick_idx;
`endif
          if (bus.req_lock[pick_idx]) begin
            state_d = ST_LOCK;
            owner_d = pick_idx;
            cnt_d   = CW'(1);
          end
        end
      end
      default: begin
        // Owner keeps the port even with others waiting; the cycle's grant
        // always completes before the lock is dropped or forced off.
        sel_idx      = owner_q;
        gnt[owner_q] = bus.req_valid[owner_q];
        cnt_d        = cnt_q + CW'(1);
        if (!bus.req_lock[owner_q]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_MAX)) begin
          state_d        = ST_IDLE;
          cnt_d          = '0;
          lock_timeout_d = 1'b1;
`ifdef REGWR_ARB_RR_EN
          ptr_d          = owner_q;
`endif
        end
      end
    endcase

    xfer    = |gnt;
    regwe_d = xfer;
    dr_d    = xfer ? bus.req_dr[AW*sel_idx +: AW]   : dr_q;
    buss_d  = xfer ? bus.req_data[DW*sel_idx +: DW] : buss_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= '0;
      cnt_q          <= '0;
      regwe_q        <= 1'b0;
      dr_q           <= '0;
      buss_q         <= '0;
      lock_timeout_q <= 1'b0;
`ifdef REGWR_ARB_RR_EN
      ptr_q          <= IW'(NREQ - 1);
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      regwe_q        <= regwe_d;
      dr_q           <= dr_d;
      buss_q         <= buss_d;
      lock_timeout_q <= lock_timeout_d;
`ifdef REGWR_ARB_RR_EN
      ptr_q          <= ptr_d;
`endif
    end
  end

  assign bus.req_ready = reset ? gnt : '0;
  assign bus.regWE     = regwe_q;
  assign bus.DR        = dr_q;
  assign bus.Buss      = buss_q;
  assign owner         = owner_q;
  assign locked        = (state_q == ST_LOCK);
  assign lock_timeout  = lock_timeout_q;

endmodule
